pipe_mips32: RTL and testbench



---
 rtl/mips32_pkg.sv | 86 ++++++++
 rtl/mips32_if.sv | 10 +
 rtl/mips32_alu.sv | 23 ++
 rtl/pipe_mips32.sv | 165 ++++++++++++++++
 tb/tb_pipe_mips32.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips32_pkg.sv
// Shared opcodes, instruction classes and pipeline-stage bundles
// for the five-stage MIPS32-subset core.
package mips32_pkg;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_AND  = 6'd2;
  localparam logic [5:0] OP_OR   = 6'd3;
  localparam logic [5:0] OP_SLT  = 6'd4;
  localparam logic [5:0] OP_MUL  = 6'd5;
  localparam logic [5:0] OP_NOP  = 6'd7;
  localparam logic [5:0] OP_LW   = 6'd8;
  localparam logic [5:0] OP_SW   = 6'd9;
  localparam logic [5:0] OP_ADDI = 6'd10;
  localparam logic [5:0] OP_SUBI = 6'd11;
  localparam logic [5:0] OP_SLTI = 6'd12;
  localparam logic [5:0] OP_BNEZ = 6'd13;
  localparam logic [5:0] OP_BEQZ = 6'd14;
  localparam logic [5:0] OP_HLT  = 6'd63;

  localparam logic [31:0] NOP_INSTR = {OP_NOP, 26'd0};

  typedef enum logic [2:0] {
    NOP    = 3'd0,
    RR_ALU = 3'd1,
    RM_ALU = 3'd2,
    LOAD   = 3'd3,
    STORE  = 3'd4,
    BRANCH = 3'd5,
    HALT   = 3'd6
  } itype_e;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } if_id_t;

  typedef struct packed {
    itype_e      t;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] npc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } id_ex_t;

  typedef struct packed {
    itype_e      t;
    logic [4:0]  dst;
    logic [31:0] alu;
    logic [31:0] b;
  } ex_mem_t;

  typedef struct packed {
    itype_e      t;
    logic [4:0]  dst;
    logic [31:0] alu;
    logic [31:0] lmd;
  } mem_wb_t;

  localparam if_id_t IFID_NOP = '{ir: NOP_INSTR, npc: 32'd0};

  function automatic itype_e decode(input logic [5:0] op);
    itype_e t;
    t = NOP;
    case (op)
      OP_ADD, OP_SUB, OP_AND,
      OP_OR, OP_SLT, OP_MUL:    t = RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI: t = RM_ALU;
      OP_LW:                    t = LOAD;
      OP_SW:                    t = STORE;
      OP_BNEZ, OP_BEQZ:         t = BRANCH;
      OP_HLT:                   t = HALT;
      default:                  t = NOP;
    endcase
    return t;
  endfunction

  function automatic logic writes_reg(input itype_e t);
    return (t == RR_ALU) || (t == RM_ALU) || (t == LOAD);
  endfunction

endpackage

// File: rtl/mips32_if.sv
// Operand/result bundle between the EX stage and the ALU.
interface mips32_if;
  logic [5:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;

  modport master (output op, a, b, input result);
  modport slave  (input op, a, b, output result);
endinterface

// File: rtl/mips32_alu.sv
// Combinational ALU; loads and stores reuse the add path
// for effective-address generation.
module mips32_alu
  import mips32_pkg::*;
(
  mips32_if.slave bus
);

  always_comb begin
    bus.result = '0;
    case (bus.op)
      OP_ADD, OP_ADDI,
      OP_LW, OP_SW:     bus.result = bus.a + bus.b;
      OP_SUB, OP_SUBI:  bus.result = bus.a - bus.b;
      OP_AND:           bus.result = bus.a & bus.b;
      OP_OR:            bus.result = bus.a | bus.b;
      OP_SLT, OP_SLTI:  bus.result = {31'd0, $signed(bus.a) < $signed(bus.b)};
      OP_MUL:           bus.result = bus.a * bus.b;
      default:          bus.result = '0;
    endcase
  end

endmodule

// File: rtl/pipe_mips32.sv
// Five-stage in-order MIPS32-subset core with unified memory,
// EX bypassing and register-file write-through.
module pipe_mips32
  import mips32_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic clk,
  input  logic rst,
  output logic halted
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:MEM_WORDS-1];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;

  logic    r_stop;
  if_id_t  r_ifid;
  id_ex_t  r_idex;
  ex_mem_t r_exmem;
  mem_wb_t r_memwb;

  id_ex_t      w_idex_nxt;
  ex_mem_t     w_exmem_nxt;
  mem_wb_t     w_memwb_nxt;
  logic [31:0] w_inst;
  logic [31:0] w_wb_val;
  logic        w_wb_we;
  logic [31:0] w_fa;
  logic [31:0] w_fb;
  logic [31:0] w_target;
  logic        w_taken;
  logic        w_id_hlt;

  mips32_if w_alu ();

  mips32_alu u_alu (
    .bus(w_alu)
  );

  assign halted = HALTED;
  assign w_inst = Mem[PC[AW-1:0]];

  assign w_wb_val = (r_memwb.t == LOAD) ? r_memwb.lmd : r_memwb.alu;
  assign w_wb_we  = !HALTED && writes_reg(r_memwb.t)
                 && (r_memwb.dst != 5'd0);

  always_comb begin
    logic [31:0] ir;
    itype_e      t;
    ir = r_ifid.ir;
    t  = decode(ir[31:26]);
    w_idex_nxt     = '0;
    w_idex_nxt.t   = t;
    w_idex_nxt.op  = ir[31:26];
    w_idex_nxt.rs  = ir[25:21];
    w_idex_nxt.rt  = ir[20:16];
    w_idex_nxt.dst = (t == RR_ALU) ? ir[15:11] : ir[20:16];
    w_idex_nxt.npc = r_ifid.npc;
    w_idex_nxt.imm = {{16{ir[15]}}, ir[15:0]};
    // Same-cycle WB write is visible to the ID read
    w_idex_nxt.a = (w_wb_we && r_memwb.dst == ir[25:21])
                 ? w_wb_val : Reg[ir[25:21]];
    w_idex_nxt.b = (w_wb_we && r_memwb.dst == ir[20:16])
                 ? w_wb_val : Reg[ir[20:16]];
  end

  assign w_id_hlt = (decode(r_ifid.ir[31:26]) == HALT);

  function automatic logic [31:0] fwd(
    input logic [4:0]  s,
    input logic [31:0] v,
    input ex_mem_t     em,
    input mem_wb_t     mw,
    input logic [31:0] wbv
  );
    if (s != 5'd0 && (em.t == RR_ALU || em.t == RM_ALU)
        && em.dst == s)
      return em.alu;
    if (s != 5'd0 && writes_reg(mw.t) && mw.dst == s)
      return wbv;
    return v;
  endfunction

  assign w_fa = fwd(r_idex.rs, r_idex.a, r_exmem, r_memwb, w_wb_val);
  assign w_fb = fwd(r_idex.rt, r_idex.b, r_exmem, r_memwb, w_wb_val);

  assign w_alu.op = r_idex.op;
  assign w_alu.a  = w_fa;
  assign w_alu.b  = (r_idex.t == RR_ALU) ? w_fb : r_idex.imm;

  assign w_target = r_idex.npc + r_idex.imm;

  always_comb begin
    w_taken = 1'b0;
    if (r_idex.t == BRANCH)
      w_taken = (r_idex.op == OP_BNEZ) ? (w_fa != 32'd0)
                                       : (w_fa == 32'd0);
  end

  always_comb begin
    w_exmem_nxt     = '0;
    w_exmem_nxt.t   = r_idex.t;
    w_exmem_nxt.dst = r_idex.dst;
    w_exmem_nxt.alu = w_alu.result;
    w_exmem_nxt.b   = w_fb;
  end

  always_comb begin
    w_memwb_nxt     = '0;
    w_memwb_nxt.t   = r_exmem.t;
    w_memwb_nxt.dst = r_exmem.dst;
    w_memwb_nxt.alu = r_exmem.alu;
    w_memwb_nxt.lmd = Mem[r_exmem.alu[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!HALTED && r_exmem.t == STORE)
      Mem[r_exmem.alu[AW-1:0]] <= r_exmem.b;
  end

  always_ff @(posedge clk) begin
    if (w_wb_we)
      Reg[r_memwb.dst] <= w_wb_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC           <= '0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      r_stop       <= 1'b0;
      r_ifid       <= IFID_NOP;
      r_idex       <= '0;
      r_exmem      <= '0;
      r_memwb      <= '0;
    end else if (!HALTED) begin
      TAKEN_BRANCH <= w_taken;
      r_exmem      <= w_exmem_nxt;
      r_memwb      <= w_memwb_nxt;
      if (r_memwb.t == HALT)
        HALTED <= 1'b1;
      if (w_taken) begin
        PC     <= w_target;
        r_ifid <= IFID_NOP;
        r_idex <= '0;
      end else begin
        r_idex <= w_idex_nxt;
        // HLT in ID stops fetch for good and freezes PC
        if (r_stop || w_id_hlt) begin
          r_stop <= 1'b1;
          r_ifid <= IFID_NOP;
        end else begin
          r_ifid <= '{ir: w_inst, npc: PC + 32'd1};
          PC     <= PC + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_mips32.sv
// Directed programs against an ISA-level reference interpreter
// plus hand-computed architectural results.
module tb_pipe_mips32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halted;

  pipe_mips32 #(.MEM_WORDS(1024)) dut (
    .clk(clk),
    .rst(rst),
    .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_reg [32];
  logic [31:0] m_mem [1024];
  int          exp_halt;
  int          exp_taken;
  logic [31:0] exp_pc;

  bit mon_en = 1'b0;
  int cyc;
  int pulses;
  int first_halt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!mon_en) begin
      cyc = 0;
      pulses = 0;
      first_halt = 0;
    end else begin
      cyc++;
      chk($sformatf("halted@%0d", cyc), {31'd0, halted},
          {31'd0, cyc >= exp_halt});
      if (dut.TAKEN_BRANCH) pulses++;
      if (halted && first_halt == 0) first_halt = cyc;
    end
  end

  task automatic poke(input int a, input logic [31:0] w);
    dut.Mem[a] = w;
    m_mem[a] = w;
  endtask

  task automatic setup();
    rst = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      dut.Mem[i] = 32'd0;
      m_mem[i] = 32'd0;
    end
    for (int i = 0; i < 32; i++) begin
      dut.Reg[i] = 32'(i);
      m_reg[i] = 32'(i);
    end
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_reg[r] = v;
  endtask

  // Sequential ISA interpreter; timing follows from one instruction
  // per cycle, 5-cycle HLT latency and 2 cycles per taken branch.
  task automatic model_run();
    logic [31:0] pc, nxt, ir, a, b, imm, ea;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  op;
    int k, t;
    bit done;
    pc = 0; k = 0; t = 0; done = 1'b0;
    while (!done && k < 500) begin
      ir  = m_mem[pc[9:0]];
      op  = ir[31:26];
      rs  = ir[25:21];
      rt  = ir[20:16];
      rd  = ir[15:11];
      a   = m_reg[rs];
      b   = m_reg[rt];
      imm = {{16{ir[15]}}, ir[15:0]};
      ea  = a + imm;
      nxt = pc + 1;
      case (op)
        6'd0:  wr(rd, a + b);
        6'd1:  wr(rd, a - b);
        6'd2:  wr(rd, a & b);
        6'd3:  wr(rd, a | b);
        6'd4:  wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        6'd5:  wr(rd, a * b);
        6'd8:  wr(rt, m_mem[ea[9:0]]);
        6'd9:  m_mem[ea[9:0]] = b;
        6'd10: wr(rt, a + imm);
        6'd11: wr(rt, a - imm);
        6'd12: wr(rt, ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0);
        6'd13: if (a != 0) begin nxt = pc + 1 + imm; t++; end
        6'd14: if (a == 0) begin nxt = pc + 1 + imm; t++; end
        6'd63: done = 1'b1;
        default: ;
      endcase
      if (!done) begin
        k++;
        pc = nxt;
      end
    end
    exp_halt  = k + 5 + 2 * t;
    exp_taken = t;
    exp_pc    = pc + 1;
  endtask

  task automatic go(input string nm);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    mon_en = 1'b1;
    for (int c = 0; c < exp_halt + 3 && c < 300; c++) @(negedge clk);
    #1;
    chk({nm, " pulses"}, 32'(pulses), 32'(exp_taken));
    chk({nm, " pc"}, dut.PC, exp_pc);
    for (int i = 0; i < 32; i++)
      chk($sformatf("%s R%0d", nm, i), dut.Reg[i], m_reg[i]);
    for (int i = 0; i < 256; i++)
      chk($sformatf("%s M%0d", nm, i), dut.Mem[i], m_mem[i]);
    mon_en = 1'b0;
  endtask

  task automatic load_ls();
    setup();
    poke(0, 32'h28010078);
    poke(1, 32'h0c631800);
    poke(2, 32'h20220000);
    poke(3, 32'h0c631800);
    poke(4, 32'h2842002d);
    poke(5, 32'h0c631800);
    poke(6, 32'h24220001);
    poke(7, 32'hfc000000);
    poke(120, 32'd85);
  endtask

  initial begin
    setup();
    repeat (2) @(negedge clk);
    chk("rst PC", dut.PC, 32'd0);
    chk("rst halted", {31'd0, halted}, 32'd0);
    chk("rst taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);

    load_ls();
    model_run();
    go("ls");
    chk("ls M121", dut.Mem[121], 32'd130);
    chk("ls R1", dut.Reg[1], 32'd120);
    chk("ls R2", dut.Reg[2], 32'd130);
    chk("ls halt cycle", 32'(first_halt), 32'd12);

    setup();
    poke(0, 32'h2801000a);
    poke(1, 32'h28220014);
    poke(2, 32'h00221800);
    poke(3, 32'hfc000000);
    model_run();
    go("fwd");
    chk("fwd R3", dut.Reg[3], 32'd40);

    setup();
    poke(0, 32'h28010007);
    poke(1, 32'h0c631800);
    poke(2, 32'h0c631800);
    poke(3, 32'h00212000);
    poke(4, 32'hfc000000);
    model_run();
    go("wt3");
    chk("wt3 R4", dut.Reg[4], 32'd14);

    setup();
    poke(0, 32'h38000002);
    poke(1, 32'h28050001);
    poke(2, 32'h28050002);
    poke(3, 32'h28060009);
    poke(4, 32'h34000005);
    poke(5, 32'h2808000b);
    poke(6, 32'hfc000000);
    model_run();
    go("br");
    chk("br R5", dut.Reg[5], 32'd5);
    chk("br R6", dut.Reg[6], 32'd9);
    chk("br R8", dut.Reg[8], 32'd11);
    chk("br pulse count", 32'(pulses), 32'd1);
    chk("br halt cycle", 32'(first_halt), 32'd11);

    setup();
    poke(0, 32'h28000005);
    poke(1, 32'hfc000000);
    poke(2, 32'h28070003);
    model_run();
    go("r0");
    chk("r0 R0", dut.Reg[0], 32'd0);
    chk("r0 R7", dut.Reg[7], 32'd7);
    chk("r0 PC", dut.PC, 32'd2);

    setup();
    poke(0, 32'h2801fffd);
    poke(1, 32'h28020006);
    poke(2, 32'h04221800);
    poke(3, 32'h08222000);
    poke(4, 32'h0c222800);
    poke(5, 32'h10223000);
    poke(6, 32'h14223800);
    poke(7, 32'h2c48000a);
    poke(8, 32'h3029fffc);
    poke(9, 32'h10415000);
    poke(10, 32'h240700c8);
    poke(11, 32'h200b00c8);
    poke(12, 32'hfc000000);
    model_run();
    go("alu");
    chk("alu SUB", dut.Reg[3], 32'hfffffff7);
    chk("alu AND", dut.Reg[4], 32'h00000004);
    chk("alu OR", dut.Reg[5], 32'hffffffff);
    chk("alu SLT", dut.Reg[6], 32'd1);
    chk("alu MUL", dut.Reg[7], 32'hffffffee);
    chk("alu SUBI", dut.Reg[8], 32'hfffffffc);
    chk("alu SLTI", dut.Reg[9], 32'd0);
    chk("alu SLT neg", dut.Reg[10], 32'd0);
    chk("alu SW->LW", dut.Reg[11], 32'hffffffee);

    load_ls();
    model_run();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b0;
    #1;
    chk("abort PC", dut.PC, 32'd0);
    chk("abort halted", {31'd0, halted}, 32'd0);
    chk("abort taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
    chk("abort M121", dut.Mem[121], 32'd0);
    chk("abort R1", dut.Reg[1], 32'd1);
    go("rerun");
    chk("rerun M121", dut.Mem[121], 32'd130);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
